hazard_fwd_unit: RTL
====================

Name: hazard_fwd_unit

Overview:
- Parametrised successor to the decode-stage hazard and bypass logic.
- Keeps a shadow pipeline of writer metadata (we, dst, is_load) for NUM_STAGES post-decode stages: stage 1 = EX, stage NUM_STAGES = WB.
- Detects load-use hazards for any load latency, and produces registered one-hot bypass selects for NUM_RD read ports.
- Sits beside the decoder and drives the IM_ID stall and the EX-stage operand muxes.

Parameters:
- NUM_RD, 2, number of register read ports.
- ADDR_W, 4, register address width. Register 0 is hardwired zero.
- NUM_STAGES, 3, shadow stages after ID (EX..WB). Must be >= 2. The bypass select is NUM_STAGES-1 bits per port.
- LOAD_STAGE, 3, first stage whose output carries load data. Range 2..NUM_STAGES.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_re  in  NUM_RD  per-port read enable.
- id_raddr  in  NUM_RD*ADDR_W  port p occupies [p*ADDR_W +: ADDR_W].
- id_we  in  1  ID instruction writes the RF.
- id_waddr  in  ADDR_W  destination register.
- id_is_load  in  1  ID instruction is a data-memory load.
- id_hold  in  1  external freeze (HLT, MOVC sequencing). ID does not advance.
- flush  in  1  kills the ID instruction (taken branch or jump).
- cond_kill  in  1  clears we of the stage-1 entry as it moves to stage 2 (ADDZ not taken).
- stall_id  out  1  combinational load-use stall for the IM_ID and PC registers.
- byp_sel  out  NUM_RD*(NUM_STAGES-1)  registered. Bit k of port p = the EX operand comes from stage k+2.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (synchronous, rst=1 at posedge): all shadow entries we=0, is_load=0, dst=0; byp_sel=0; stall_cnt=0. Reset mid-operation discards every in-flight entry. The first cycle after reset sees no hazards and no bypasses.
- Match rule:
  - Port p matches stage k when id_valid & id_re[p] & raddr_p!=0 & S[k].we & S[k].dst==raddr_p.
  - The youngest match (lowest k) is the only relevant one. Older matches are ignored.
- Load-use hazard:
  - Asserted when port p's youngest match is at stage k with S[k].is_load and k+1 < LOAD_STAGE.
  - hazard = OR over all ports.
  - stall_id = hazard & !flush. Flush overrides, because the killed instruction needs no stall.
- advance = !stall_id & !id_hold & !flush.
- Every posedge (rst=0):
  - S[k+1] <= S[k] for k>=1. At the 1->2 transfer, we is ANDed with !cond_kill.
  - S[1] <= advance ? {id_we & id_valid, id_waddr, id_is_load & id_valid} : bubble (we=0, is_load=0).
- byp_sel, per port p, on each posedge:
  - If advance, and the youngest match is stage k with k <= NUM_STAGES-1: byp_sel bit k-1 <= 1 and all other bits of port p <= 0. Stage k becomes stage k+1, so the bit means "source = stage k+1".
  - Otherwise the port's bits <= 0. This covers a bubble entering EX, a match at stage NUM_STAGES (RF write-before-read covers it), and no match.
  - The output is always one-hot or zero per port.
- Load latency:
  - A load in stage k stalls a dependent instruction for LOAD_STAGE-1-k cycles.
  - Defaults give 1 stall cycle, then a bypass from stage 3.
  - Multi-cycle stalls need no state machine, because the load advances each cycle while bubbles are inserted.
- cond_kill and flush are sampled only on the cycle they are asserted.
- stall_cnt increments when stall_id=1 and holds at all-ones. It does not wrap.
- Latency: stall_id is 0-cycle combinational. byp_sel is valid in the cycle the consumer sits in EX.

Test Plan:
1. ADD R3 (id_we, waddr=3), then next cycle SUB reading R3 on both ports.
   - Expect no stall.
   - In SUB's EX cycle, byp_sel port0 = port1 = 2'b01 (from DM).
2. LW R4, then ADD reading R4 on port0.
   - Expect stall_id=1 for exactly 1 cycle, after which stall_cnt=1.
   - ADD then enters EX with byp_sel port0 = 2'b10 and port1 = 2'b00.
3. Rerun scenario 2 with LOAD_STAGE=4 and NUM_STAGES=4.
   - Expect 2 consecutive stall cycles, then port0 byp_sel = 3'b100.
4. Write R0, then read R0 on both ports.
   - Expect no stall and byp_sel=0.
   - Also: ADD R5, ADD R5, then read R5. Expect the youngest writer wins: byp_sel = 2'b01, never 2'b11.
5. ADDZ R7 with cond_kill=1 as it leaves EX, then read R7 one instruction later.
   - Expect byp_sel=0 (falls back to RF).
6. Load-use stall with flush=1 in the same cycle.
   - Expect stall_id=0 and a bubble in S[1].
   - rst=1 mid-stream: expect stall_id=0 and byp_sel=0 the next cycle, and stall_cnt=0.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
//
// Decode-stage hazard detection and operand-bypass selection. A shadow
// pipeline mirrors the writer metadata (we, dst, is_load) of every
// instruction after ID: stage 1 = EX ... stage NUM_STAGES = WB. The reads of
// the instruction in ID are compared against it to produce a load-use stall
// and a registered one-hot bypass select, which is valid in the consumer's
// EX cycle.
//
// Ports
//   clk        : clock
//   rst        : synchronous reset, active-high
//   id_valid   : ID holds a real instruction
//   id_re      : per-port read enable            [NUM_RD]
//   id_raddr   : read addresses, port p at [p*ADDR_W +: ADDR_W]
//   id_we      : ID instruction writes the register file
//   id_waddr   : ID destination register
//   id_is_load : ID instruction is a data-memory load
//   id_hold    : external freeze, ID does not advance
//   flush      : kills the ID instruction
//   cond_kill  : clears we of the stage-1 entry as it moves to stage 2
//   stall_id   : combinational load-use stall for IM_ID / PC
//   byp_sel    : registered bypass select, bit k of port p = source stage k+2
//   stall_cnt  : saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module hazard_fwd_unit #(
  parameter int NUM_RD     = 2,
  parameter int ADDR_W     = 4,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_STAGE = 3,
  parameter int CNT_W      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                id_valid,
  input  logic [NUM_RD-1:0]                   id_re,
  input  logic [NUM_RD*ADDR_W-1:0]            id_raddr,
  input  logic                                id_we,
  input  logic [ADDR_W-1:0]                   id_waddr,
  input  logic                                id_is_load,
  input  logic                                id_hold,
  input  logic                                flush,
  input  logic                                cond_kill,
  output logic                                stall_id,
  output logic [NUM_RD*(NUM_STAGES-1)-1:0]    byp_sel,
  output logic [CNT_W-1:0]                    stall_cnt
);

  localparam int BW = NUM_STAGES - 1;

  // Shadow pipeline, indexed by stage number (1 = EX).
  logic [NUM_STAGES:1] s_we_reg;
  logic [NUM_STAGES:1] s_ld_reg;
  logic [ADDR_W-1:0]   s_dst_reg [1:NUM_STAGES];

  logic [NUM_RD*BW-1:0] byp_sel_reg;
  logic [NUM_RD*BW-1:0] byp_sel_next;
  logic [CNT_W-1:0]     stall_cnt_reg;

  logic [NUM_RD-1:0]    port_haz;
  logic                 hazard;
  logic                 advance;

  // Stages whose output is still too early to carry load data for a
  // consumer that would enter EX next cycle: k + 1 < LOAD_STAGE.
  logic [NUM_STAGES:1]  early_mask;

  genvar gi;

  for (gi = 1; gi <= NUM_STAGES; gi++) begin : g_early
    assign early_mask[gi] = (gi + 1 < LOAD_STAGE);
  end

  // -------------------------------------------------------------------------
  // Per-read-port match, youngest-writer priority and bypass select.
  // -------------------------------------------------------------------------
  for (gi = 0; gi < NUM_RD; gi++) begin : g_port
    logic [ADDR_W-1:0]   raddr;
    logic                rd_active;
    logic [NUM_STAGES:1] hit;
    logic [NUM_STAGES:1] youngest;
    logic                seen;

    assign raddr     = id_raddr[gi*ADDR_W +: ADDR_W];
    // Register 0 is hardwired zero and never needs a bypass.
    assign rd_active = id_valid & id_re[gi] & (raddr != '0);

    always_comb begin
      hit = '0;
      for (int k = 1; k <= NUM_STAGES; k++) begin
        hit[k] = rd_active & s_we_reg[k] & (s_dst_reg[k] == raddr);
      end
    end

    // Keep only the lowest-numbered (youngest) match; older writers to the
    // same register hold stale values.
    always_comb begin
      youngest = '0;
      seen     = 1'b0;
      for (int k = 1; k <= NUM_STAGES; k++) begin
        youngest[k] = hit[k] & ~seen;
        seen        = seen | hit[k];
      end
    end

    assign port_haz[gi] = |(youngest & s_ld_reg & early_mask);

    // A match at stage k moves to stage k+1 as the consumer enters EX, so
    // youngest bit k lands on byp_sel bit k-1 ("source = stage k+1"). A match
    // at the last stage is dropped: the RF write-before-read covers it.
    assign byp_sel_next[gi*BW +: BW] = advance ? youngest[NUM_STAGES-1:1] : '0;
  end

  assign hazard   = |port_haz;
  // A flushed instruction never reaches EX, so it must not stall the front end.
  assign stall_id = hazard & ~flush;
  assign advance  = ~stall_id & ~id_hold & ~flush;

  // -------------------------------------------------------------------------
  // Shadow pipeline. Multi-cycle load latency needs no extra state: the load
  // keeps moving while bubbles are inserted behind it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s_we_reg <= '0;
      s_ld_reg <= '0;
      for (int k = 1; k <= NUM_STAGES; k++) begin
        s_dst_reg[k] <= '0;
      end
    end else begin
      s_we_reg[1]  <= advance & id_we & id_valid;
      s_ld_reg[1]  <= advance & id_is_load & id_valid;
      s_dst_reg[1] <= advance ? id_waddr : '0;

      // A conditional write (ADDZ not taken) is cancelled as it leaves EX.
      s_we_reg[2]  <= s_we_reg[1] & ~cond_kill;
      s_ld_reg[2]  <= s_ld_reg[1];
      s_dst_reg[2] <= s_dst_reg[1];

      for (int k = 3; k <= NUM_STAGES; k++) begin
        s_we_reg[k]  <= s_we_reg[k-1];
        s_ld_reg[k]  <= s_ld_reg[k-1];
        s_dst_reg[k] <= s_dst_reg[k-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Bypass select register and saturating stall statistics.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_sel_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      byp_sel_reg <= byp_sel_next;
      if (stall_id && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign byp_sel   = byp_sel_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
